// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_ctrl block.
package fifo_pkg;

  localparam int DEFAULT_WORD_SIZE = 10;
  localparam int DEFAULT_DEPTH     = 8;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one write port and one registered read port.
// The array itself is never reset; only the read register clears.
import fifo_pkg::*;

module fifo_ram #(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PTR       = ptr_width(DEFAULT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [PTR-1:0]       waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [PTR-1:0]       raddr,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [DEPTH];

  // Write port; no reset so stale words simply become unreachable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; reads the pre-write value when addresses collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, status flags and
// optional sticky error flags. Define FIFO_ERR_FLAGS_EN to enable the
// overflow/underflow registers; otherwise both outputs are tied to 0.
import fifo_pkg::*;

module fifo_ctrl #(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  localparam int PTR      = ptr_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR:0]         count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [PTR:0] DEPTH_CNT = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] AF_CNT    = (PTR+1)'(AF_THRESH);
  localparam logic [PTR:0] AE_CNT    = (PTR+1)'(AE_THRESH);

  logic [PTR-1:0] wr_ptr;
  logic [PTR-1:0] rd_ptr;
  logic           push_acc;
  logic           pop_acc;

  // A full FIFO still takes a push when a pop frees the head slot.
  always_comb begin
    pop_acc  = pop && !empty;
    push_acc = push && (!full || pop);
  end

  // Status flags decoded from the registered occupancy.
  always_comb begin
    full         = (count == DEPTH_CNT);
    empty        = (count == '0);
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: unchanged when a push and a pop are both accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read strobe follows an accepted pop by exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_valid <= 1'b0;
    else       data_valid <= pop_acc;
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop) overflow  <= 1'b1;
      if (pop && empty)         underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  fifo_ram #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH),
    .PTR       (PTR)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (pop_acc),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference.
module tb_fifo_ctrl;

  localparam int WS    = 10;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic [WS-1:0] data_in;
  logic [WS-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  fifo_ctrl #(
    .WORD_SIZE (WS),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [WS-1:0] m_q[$];
  logic [WS-1:0] m_dout;
  logic          m_dv;
  logic          m_ovf;
  logic          m_udf;

  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    int sz;
    sz = m_q.size();
    chk({tag, ".count"},  int'(count),        sz);
    chk({tag, ".full"},   int'(full),         int'(sz == DEPTH));
    chk({tag, ".empty"},  int'(empty),        int'(sz == 0));
    chk({tag, ".afull"},  int'(almost_full),  int'(sz >= AF));
    chk({tag, ".aempty"}, int'(almost_empty), int'(sz <= AE));
    chk({tag, ".dv"},     int'(data_valid),   int'(m_dv));
    chk({tag, ".dout"},   int'(data_out),     int'(m_dout));
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, ".ovf"},    int'(overflow),     int'(m_ovf));
    chk({tag, ".udf"},    int'(underflow),    int'(m_udf));
`else
    chk({tag, ".ovf"},    int'(overflow),     0);
    chk({tag, ".udf"},    int'(underflow),    0);
`endif
  endtask

  // One clock with the given request; called at a falling edge.
  task automatic cycle(input string tag, input logic p, input logic q, input logic [WS-1:0] d);
    int sz;
    push    = p;
    pop     = q;
    data_in = d;
    sz = m_q.size();
    if (p && sz == DEPTH && !q) m_ovf = 1'b1;
    if (q && sz == 0)           m_udf = 1'b1;
    if (q && sz > 0) begin
      m_dout = m_q.pop_front();
      m_dv   = 1'b1;
    end else begin
      m_dv   = 1'b0;
    end
    if (p && (sz < DEPTH || q)) m_q.push_back(d);
    @(posedge clk);
    #1;
    chk_all(tag);
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    m_q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    chk_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    reset   = 1'b0;
    @(negedge clk);
    do_reset("rst0");

    // Fill with 1..8 then drain in order
    for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, 1'b0, WS'(i));
    for (int i = 1; i <= DEPTH; i++) cycle("drain", 1'b0, 1'b1, '0);

    // Full: dropped push, then push with pop, then drain
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 1'b0, WS'(16 + i));
    cycle("drop", 1'b1, 1'b0, 10'h3FF);
    cycle("fullpp", 1'b1, 1'b1, 10'h2AA);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 1'b1, '0);

    // Empty: pop with push is not a fall-through
    cycle("emptypp", 1'b1, 1'b1, 10'h155);
    cycle("pop155", 1'b0, 1'b1, '0);
    cycle("idle", 1'b0, 1'b0, '0);

    // Interleaved traffic past the wrap point, then reset at count 5
    do_reset("rst1");
    for (int i = 0; i < 12; i++) begin
      cycle("wrap_push", 1'b1, 1'b0, WS'(32 + i));
      if (i % 2 == 1) cycle("wrap_pop", 1'b0, 1'b1, '0);
    end
    for (int i = 0; i < 6; i++) cycle("wrap_pop2", 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 1'b0, WS'(64 + i));
    do_reset("rst_mid");
    cycle("post_push", 1'b1, 1'b0, 10'h0AA);
    cycle("post_pop", 1'b0, 1'b1, '0);

    // Randomized traffic with occasional mid-run reset
    for (int i = 0; i < 600; i++) begin
      logic p, q;
      int   bias;
      bias = (i / 100) % 2;
      p = ($urandom_range(99) < (bias ? 70 : 35));
      q = ($urandom_range(99) < (bias ? 35 : 70));
      if ($urandom_range(199) == 0) do_reset("rnd_rst");
      else cycle("rnd", p, q, WS'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
